// File: rtl/qspi_target_pkg.sv
// qspi_pkg: shared types and command codes for the quad-SPI target.
//  qspi_tgt_state_t - top-level FSM states
//  CMD_*            - recognised command bytes
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, STATUS, IGNORE
  } qspi_tgt_state_t;

  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [7:0] CMD_STATUS = 8'h05;

endpackage

// File: rtl/qspi_target_if.sv
// qspi_target_if: simple word bus between the QSPI target and memory.
//  master : target side (drives req_o/we_o/addr_o/wdata_o, takes gnt_i/rvalid_i/rdata_i)
//  slave  : memory side
interface qspi_target_if;
  logic        req_o;
  logic        we_o;
  logic [23:0] addr_o;
  logic [31:0] wdata_o;
  logic        gnt_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;

  modport master (output req_o, we_o, addr_o, wdata_o, input gnt_i, rvalid_i, rdata_i);
  modport slave  (input req_o, we_o, addr_o, wdata_o, output gnt_i, rvalid_i, rdata_i);
endinterface

// File: rtl/qspi_target_sync.sv
// qspi_target_sync: brings sclk_i/cs_i/sd_i into the clk_i domain and
// produces one-cycle edge pulses.
//  in : clk_i, rst_i (sync, active-high), sclk_i, cs_i, sd_i[3:0]
//  out: sclk_rise/sclk_fall, cs_fall/cs_rise pulses, cs_s level, sd_s nibble
module qspi_target_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sclk_i,
  input  logic       cs_i,
  input  logic [3:0] sd_i,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       cs_s,
  output logic [3:0] sd_s
);

  logic [SYNC_STAGES-1:0]      sclk_q, cs_q;
  logic [SYNC_STAGES-1:0][3:0] sd_q;
  logic                        sclk_d, cs_d;

  // cs chain resets low: a frame already in progress when reset drops must
  // not produce a fall pulse, only a genuine later fall starts a transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q <= '0;
      cs_q   <= '0;
      sd_q   <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_i};
      sd_q   <= {sd_q[SYNC_STAGES-2:0], sd_i};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      cs_d   <= cs_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
  assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_d;
  assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_d;
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign sd_s      = sd_q[SYNC_STAGES-1];

endmodule

// File: rtl/qspi_target.sv
// qspi_target: quad-SPI responder bridging SPI frames onto a word bus.
//  clk_i, rst_i (sync, active-high)
//  sclk_i, cs_i, sd_i[3:0]  : SPI pins from the master (mode 0)
//  sd_o[3:0], sd_oe[3:0]    : SPI data out and per-lane enable
//  err_o                    : sticky error, cleared by a status read
//  bus                      : word bus (master modport)
module qspi_target
  import qspi_pkg::*;
#(
  parameter int DUMMY_CYCLES = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sclk_i,
  input  logic          cs_i,
  input  logic [3:0]    sd_i,
  output logic [3:0]    sd_o,
  output logic [3:0]    sd_oe,
  output logic          err_o,
  qspi_target_if.master bus
);

  localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYCLES - 1);

  logic            sclk_rise, sclk_fall, cs_fall, cs_rise, cs_s;
  logic [3:0]      sd_s;
  qspi_tgt_state_t state, state_n;
  logic [4:0]      cnt;
  logic [27:0]     sh_rx;
  logic [31:0]     nib_word, tx_sh, tx_buf, wdata_q, word_in;
  logic [23:0]     addr_q, baddr_q;
  logic [3:0]      sd_q;
  logic            is_wr, oe_q, err_q, req_q, we_q, rd_pend, buf_vld;
  logic            cs_idle, rise, fall, rd_hit, word_rdy;

  qspi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i(clk_i), .rst_i(rst_i), .sclk_i(sclk_i), .cs_i(cs_i), .sd_i(sd_i),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .cs_fall(cs_fall),
    .cs_rise(cs_rise), .cs_s(cs_s), .sd_s(sd_s)
  );

  // cs high masks sclk edges in the same sample: cs wins, nibble dropped.
  assign cs_idle  = cs_s | cs_rise;
  assign rise     = sclk_rise & ~cs_idle;
  assign fall     = sclk_fall & ~cs_idle;
  assign nib_word = {sh_rx, sd_s};
  assign rd_hit   = bus.rvalid_i & rd_pend;
  assign word_rdy = buf_vld | rd_hit;
  assign word_in  = buf_vld ? tx_buf : bus.rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (cs_idle) state_n = IDLE;
    else begin
      case (state)
        IDLE:  if (cs_fall) state_n = CMD;
        CMD:   if (rise && cnt == 5'd1) begin
                 case (nib_word[7:0])
                   CMD_QREAD, CMD_QWRITE: state_n = ADDR;
                   CMD_STATUS:            state_n = STATUS;
                   default:               state_n = IGNORE;
                 endcase
               end
        ADDR:  if (rise && cnt == 5'd5) state_n = is_wr ? WDATA : DUMMY;
        DUMMY: if (rise && cnt == DUMMY_LAST) state_n = RDATA;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0; sh_rx <= '0; tx_sh <= '0; tx_buf <= '0; wdata_q <= '0;
      addr_q <= '0; baddr_q <= '0; sd_q <= '0; is_wr <= 1'b0; oe_q <= 1'b0;
      err_q <= 1'b0; req_q <= 1'b0; we_q <= 1'b0; rd_pend <= 1'b0; buf_vld <= 1'b0;
    end else begin
      // Bus side runs regardless of SPI state so in-flight requests complete.
      if (bus.gnt_i) req_q <= 1'b0;
      if (rd_hit) begin
        rd_pend <= 1'b0;
        tx_buf  <= bus.rdata_i;
        buf_vld <= 1'b1;
      end
      if (cs_idle) begin
        cnt  <= '0;
        oe_q <= 1'b0;
      end else begin
        case (state)
          IDLE: cnt <= '0;
          CMD: if (rise) begin
            sh_rx <= nib_word[27:0];
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd1) begin
              cnt   <= '0;
              is_wr <= (nib_word[7:0] == CMD_QWRITE);
              if (!(nib_word[7:0] inside {CMD_QREAD, CMD_QWRITE, CMD_STATUS})) err_q <= 1'b1;
            end
          end
          ADDR: if (rise) begin
            sh_rx <= nib_word[27:0];
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd5) begin
              cnt    <= '0;
              addr_q <= {nib_word[23:2], 2'b00};
              if (!is_wr) begin
                req_q   <= 1'b1;
                we_q    <= 1'b0;
                baddr_q <= {nib_word[23:2], 2'b00};
                rd_pend <= 1'b1;
                buf_vld <= 1'b0;
              end
            end
          end
          DUMMY: if (rise) begin
            cnt <= cnt + 5'd1;
            if (cnt == DUMMY_LAST) begin
              cnt     <= '0;
              tx_sh   <= word_rdy ? word_in : 32'h0;
              buf_vld <= 1'b0;
              if (!word_rdy) err_q <= 1'b1;
            end
          end
          RDATA: begin
            if (fall) begin
              oe_q  <= 1'b1;
              sd_q  <= tx_sh[31:28];
              tx_sh <= {tx_sh[27:0], 4'h0};
            end
            if (rise) begin
              cnt <= cnt + 5'd1;
              // First rise of a word: fetch the following word.
              if (cnt == 5'd0) begin
                addr_q  <= addr_q + 24'd4;
                req_q   <= 1'b1;
                we_q    <= 1'b0;
                baddr_q <= addr_q + 24'd4;
                rd_pend <= 1'b1;
                buf_vld <= 1'b0;
              end
              if (cnt == 5'd7) begin
                cnt     <= '0;
                tx_sh   <= word_rdy ? word_in : 32'h0;
                buf_vld <= 1'b0;
                if (!word_rdy) err_q <= 1'b1;
              end
            end
          end
          WDATA: if (rise) begin
            sh_rx <= nib_word[27:0];
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd7) begin
              cnt <= '0;
              if (req_q && !bus.gnt_i) err_q <= 1'b1;
              else begin
                req_q   <= 1'b1;
                we_q    <= 1'b1;
                wdata_q <= nib_word;
                baddr_q <= addr_q;
                addr_q  <= addr_q + 24'd4;
              end
            end
          end
          STATUS: if (fall) begin
            oe_q <= 1'b1;
            sd_q <= cnt[0] ? {2'b00, err_q, req_q} : 4'h0;
            cnt  <= {4'b0, ~cnt[0]};
            if (cnt[0]) err_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    sd_oe = 4'h0;
    if ((state == RDATA || state == STATUS) && oe_q) sd_oe = 4'hF;
  end

  assign sd_o        = sd_q;
  assign err_o       = err_q;
  assign bus.req_o   = req_q;
  assign bus.we_o    = we_q;
  assign bus.addr_o  = baddr_q;
  assign bus.wdata_o = wdata_q;

endmodule
